prog_loader: RTL and testbench

//  Boot-time program loader upstream of the single-cycle core's instruction memory.

---
 rtl/prog_loader_pkg.sv | 16 +
 rtl/prog_loader_byte_packer.sv | 33 +++
 rtl/prog_loader.sv | 184 ++++++++++++++++++
 tb/tb_prog_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM state encodings
// and checksum width.
package prog_loader_pkg;

  localparam int CSUM_W = 8;

  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Packs a byte stream into little-endian 32-bit words. word/word_valid are
// combinational so the parent can register the write on the 4th byte's edge.
module byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [23:0] shift_reg;
  logic [1:0]  cnt_reg;

  assign word_valid = in_valid && (cnt_reg == 2'd3);
  assign word       = {in_byte, shift_reg};

  // Oldest byte drifts to the bottom, so after three bytes shift_reg = {b2,b1,b0}.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else if (clear) begin
      shift_reg <= '0;
      cnt_reg   <= '0;
    end else if (in_valid) begin
      shift_reg <= {in_byte, shift_reg[23:8]};
      cnt_reg   <= cnt_reg + 2'd1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: parses LEN/payload/CSUM frames from a byte
// stream, writes words to instruction memory and releases the core on success.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_waddr,
  output logic [31:0]       im_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

  state_t              state_reg, state_next;
  logic [7:0]          len_lo_reg, len_lo_next;
  logic [ADDR_W:0]     len_reg, len_next;
  logic [ADDR_W:0]     word_idx_reg, word_idx_next;
  logic [ADDR_W:0]     word_idx_inc;
  logic [CSUM_W-1:0]   csum_reg, csum_next;
  logic                byte_ready_reg, byte_ready_next;
  logic                im_we_reg, im_we_next;
  logic [ADDR_W-1:0]   im_waddr_reg, im_waddr_next;
  logic [31:0]         im_wdata_reg, im_wdata_next;
  logic                core_hold_reg, core_hold_next;
  logic                done_reg, done_next;
  logic                error_reg, error_next;

  logic                accept;
  logic [15:0]         len_full;
  logic                pack_valid;
  logic                pack_clear;
  logic                word_valid;
  logic [31:0]         word;

  assign accept       = byte_valid && byte_ready_reg;
  assign len_full     = {byte_data, len_lo_reg};
  assign word_idx_inc = word_idx_reg + {{ADDR_W{1'b0}}, 1'b1};
  assign pack_valid   = accept && (state_reg == S_DATA);
  assign pack_clear   = reload && ((state_reg == S_DONE) || (state_reg == S_ERR));

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pack_clear),
    .in_valid   (pack_valid),
    .in_byte    (byte_data),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_LEN0;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    len_lo_next    = len_lo_reg;
    len_next       = len_reg;
    word_idx_next  = word_idx_reg;
    csum_next      = csum_reg;
    im_we_next     = 1'b0;
    im_waddr_next  = im_waddr_reg;
    im_wdata_next  = im_wdata_reg;
    core_hold_next = core_hold_reg;
    done_next      = done_reg;
    error_next     = error_reg;

    case (state_reg)
      S_LEN0: begin
        if (accept) begin
          len_lo_next = byte_data;
          state_next  = S_LEN1;
        end
      end
      S_LEN1: begin
        if (accept) begin
          len_next = len_full[ADDR_W:0];
          if ({1'b0, len_full} > MAX_WORDS) begin
            state_next = S_ERR;
            error_next = 1'b1;
          end else if (len_full == 16'd0) begin
            state_next = S_CSUM;
          end else begin
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_next = csum_reg ^ byte_data;
          if (word_valid) begin
            im_we_next    = 1'b1;
            im_waddr_next = word_idx_reg[ADDR_W-1:0];
            im_wdata_next = word;
            word_idx_next = word_idx_inc;
            if (word_idx_inc == len_reg) begin
              state_next = S_CSUM;
            end
          end
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (byte_data == csum_reg) begin
            state_next     = S_DONE;
            done_next      = 1'b1;
            core_hold_next = 1'b0;
          end else begin
            state_next = S_ERR;
            error_next = 1'b1;
          end
        end
      end
      S_DONE, S_ERR: begin
        if (reload) begin
          state_next     = S_LEN0;
          done_next      = 1'b0;
          error_next     = 1'b0;
          core_hold_next = 1'b1;
          len_lo_next    = '0;
          len_next       = '0;
          word_idx_next  = '0;
          csum_next      = '0;
        end
      end
      default: state_next = S_LEN0;
    endcase

    // Ready tracks the state being entered so it is valid as a registered output.
    byte_ready_next = (state_next == S_LEN0) || (state_next == S_LEN1) ||
                      (state_next == S_DATA) || (state_next == S_CSUM);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_lo_reg     <= '0;
      len_reg        <= '0;
      word_idx_reg   <= '0;
      csum_reg       <= '0;
      byte_ready_reg <= 1'b0;
      im_we_reg      <= 1'b0;
      im_waddr_reg   <= '0;
      im_wdata_reg   <= '0;
      core_hold_reg  <= 1'b1;
      done_reg       <= 1'b0;
      error_reg      <= 1'b0;
    end else begin
      len_lo_reg     <= len_lo_next;
      len_reg        <= len_next;
      word_idx_reg   <= word_idx_next;
      csum_reg       <= csum_next;
      byte_ready_reg <= byte_ready_next;
      im_we_reg      <= im_we_next;
      im_waddr_reg   <= im_waddr_next;
      im_wdata_reg   <= im_wdata_next;
      core_hold_reg  <= core_hold_next;
      done_reg       <= done_next;
      error_reg      <= error_next;
    end
  end

  assign byte_ready = byte_ready_reg;
  assign im_we      = im_we_reg;
  assign im_waddr   = im_waddr_reg;
  assign im_wdata   = im_wdata_reg;
  assign core_hold  = core_hold_reg;
  assign done       = done_reg;
  assign error      = error_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of frames plus hand-written
// reset/overflow/reload sequences; memory writes checked against a scoreboard.
module tb_prog_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              reload = 1'b0;
  logic              im_we;
  logic [ADDR_W-1:0] im_waddr;
  logic [31:0]       im_wdata;
  logic              core_hold;
  logic              done;
  logic              error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    int         len;
    logic [7:0] seed;
    logic [7:0] csum_flip;
    int         gap;
    bit         exp_done;
  } frame_t;
  frame_t tbl[7];

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .reload     (reload),
    .im_we      (im_we),
    .im_waddr   (im_waddr),
    .im_wdata   (im_wdata),
    .core_hold  (core_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every im_we pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && im_we) begin
      wr_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h", im_waddr, im_wdata);
      end else begin
        e = sb.pop_front();
        if (im_waddr !== e.addr || im_wdata !== e.data) begin
          errors++;
          $display("FAIL write actual=%h:%h required=%h:%h", im_waddr, im_wdata, e.addr, e.data);
        end
      end
    end
  end

  function automatic logic [31:0] gen_word(input logic [7:0] seed, input int i);
    logic [31:0] k;
    if (seed == 8'h00) return (i == 0) ? 32'h12345678 : 32'hDEADBEEF;
    k = 32'(i + 1);
    return (32'h9E3779B9 * k) ^ {4{seed}};
  endfunction

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    byte_valid = 1'b0;
    repeat ($urandom_range(gap)) @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=byte_ready_low required=accept byte=%h", b);
      byte_valid = 1'b0;
      return;
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_payload(input int len, input logic [7:0] seed, input int gap,
                              output logic [7:0] csum);
    logic [31:0] w;
    logic [7:0]  b;
    wr_t         e;
    csum = 8'h00;
    for (int i = 0; i < len; i++) begin
      w = gen_word(seed, i);
      for (int j = 0; j < 4; j++) begin
        b = w[8*j +: 8];
        csum ^= b;
        if (j == 3) begin
          e.addr = ADDR_W'(i);
          e.data = w;
          sb.push_back(e);
        end
        send_byte(b, gap);
      end
    end
  endtask

  task automatic run_frame(input int len, input logic [7:0] seed, input logic [7:0] flip,
                           input int gap);
    logic [7:0]  csum;
    logic [15:0] l;
    l = 16'(len);
    send_byte(l[7:0], gap);
    send_byte(l[15:8], gap);
    send_payload(len, seed, gap, csum);
    send_byte(csum ^ flip, gap);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  initial begin
    logic [7:0] csum;
    wr_t        e;

    tbl[0] = '{2,   8'h00, 8'h00, 0, 1'b1};
    tbl[1] = '{2,   8'h00, 8'h01, 0, 1'b0};
    tbl[2] = '{0,   8'h11, 8'h00, 0, 1'b1};
    tbl[3] = '{5,   8'h22, 8'h00, 3, 1'b1};
    tbl[4] = '{5,   8'h22, 8'h00, 0, 1'b1};
    tbl[5] = '{256, 8'h33, 8'h00, 0, 1'b1};
    tbl[6] = '{3,   8'h44, 8'h80, 2, 1'b0};

    // Reset values
    @(negedge clk);
    check("rst_byte_ready", byte_ready, 0);
    check("rst_core_hold", core_hold, 1);
    check("rst_im_we", im_we, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_waddr", im_waddr, 0);
    check("rst_wdata", im_wdata, 0);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", byte_ready, 1);

    for (int t = 0; t < 7; t++) begin
      run_frame(tbl[t].len, tbl[t].seed, tbl[t].csum_flip, tbl[t].gap);
      $display("frame %0d len=%0d done=%0b error=%0b core_hold=%0b", t, tbl[t].len, done, error, core_hold);
      check("frame_done", done, tbl[t].exp_done);
      check("frame_error", error, !tbl[t].exp_done);
      check("frame_core_hold", core_hold, !tbl[t].exp_done);
      check("frame_ready", byte_ready, 0);
      check("frame_sb_drained", sb.size(), 0);
      do_reload();
      check("reload_done", done, 0);
      check("reload_error", error, 0);
      check("reload_core_hold", core_hold, 1);
      check("reload_ready", byte_ready, 1);
    end

    // Length overflow: error right after the second length byte, no writes
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    $display("overflow len=0x0101 error=%0b byte_ready=%0b", error, byte_ready);
    check("ovf_error", error, 1);
    check("ovf_ready", byte_ready, 0);
    check("ovf_core_hold", core_hold, 1);
    repeat (3) @(negedge clk);
    check("ovf_still_error", error, 1);
    do_reload();

    // Async reset mid-payload after 6 data bytes
    send_byte(8'h02, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] w;
      w = gen_word(8'h55, i / 4);
      if (i == 3) begin
        e.addr = '0;
        e.data = w;
        sb.push_back(e);
      end
      send_byte(w[8*(i%4) +: 8], 0);
    end
    #2 rst = 1'b0;
    #1;
    $display("mid_reset byte_ready=%0b core_hold=%0b im_we=%0b", byte_ready, core_hold, im_we);
    check("mid_rst_ready", byte_ready, 0);
    check("mid_rst_core_hold", core_hold, 1);
    check("mid_rst_im_we", im_we, 0);
    check("mid_rst_waddr", im_waddr, 0);
    check("mid_rst_sb", sb.size(), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Fresh frame loads from addr 0; reload mid-frame must be ignored
    send_byte(8'h01, 0);
    do_reload();
    send_byte(8'h00, 0);
    send_payload(1, 8'h66, 0, csum);
    send_byte(csum, 0);
    $display("fresh frame done=%0b error=%0b", done, error);
    check("fresh_done", done, 1);
    check("fresh_core_hold", core_hold, 0);
    check("fresh_sb_drained", sb.size(), 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
